pll_reset_sequencer: RTL and testbench

//   Supervises the CC_PLL lock outputs and sequences the system reset.
//   - Pulses the PLL's USR_LOCKED_STDY_RST input to re-arm lock monitoring.
//   - Waits for lock, then requires lock to hold continuously before releasing sys_rst.
//   - Detects lock loss and re-sequences. Retries on lock timeout; after MAX_RETRIES, latches fault.
//   - Runs on the free-running board reference clock, upstream of the PLL output clock domain.

---
 rtl/pll_reset_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Supervises the CC_PLL lock outputs on the free-running reference clock:
// re-arms lock monitoring, qualifies lock, releases sys_rst and retries or faults.
module pll_reset_sequencer #(
    parameter int STDY_RST_CYCLES     = 4,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clock_in,
    input  logic       rst_in,
    input  logic       pll_locked,
    input  logic       pll_locked_stdy,
    output logic       stdy_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count
);

    localparam int CNT_AB  = (STDY_RST_CYCLES > LOCK_STABLE_CYCLES) ? STDY_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX = (CNT_AB > LOCK_TIMEOUT_CYCLES) ? CNT_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] STDY_LAST   = CNT_W'(STDY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_lk_meta;
    logic             r_lk_s;
    logic             r_st_meta;
    logic             r_st_s;
    logic             r_lock_lost;
    logic [3:0]       r_retry_count;
    logic [7:0]       r_loss_count;
    logic             w_good;
    logic             w_timeout;
    logic             w_loss;
    logic [3:0]       w_retry_sat;
    logic [7:0]       w_loss_sat;

    // Two-flop synchronisers for the asynchronous PLL status lines
    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
            r_st_meta <= 1'b0;
            r_st_s    <= 1'b0;
        end else begin
            r_lk_meta <= pll_locked;
            r_lk_s    <= r_lk_meta;
            r_st_meta <= pll_locked_stdy;
            r_st_s    <= r_st_meta;
        end
    end

    assign w_good      = r_lk_s & r_st_s;
    assign w_retry_sat = (r_retry_count == 4'hF) ? r_retry_count : r_retry_count + 4'd1;
    assign w_loss_sat  = (r_loss_count == 8'hFF) ? r_loss_count : r_loss_count + 8'd1;

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            r_state       <= S_RESET_PLL;
            r_cnt         <= '0;
            r_lock_lost   <= 1'b0;
            r_retry_count <= 4'd0;
            r_loss_count  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lock_lost <= w_loss;
            if (w_timeout) begin
                r_retry_count <= w_retry_sat;
            end
            if (w_loss) begin
                r_loss_count <= w_loss_sat;
            end
        end
    end

    // cnt is cleared on every state change so it can never wrap
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_timeout   = 1'b0;
        w_loss      = 1'b0;
        case (r_state)
            S_RESET_PLL: begin
                if (r_cnt == STDY_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (w_good) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (w_retry_sat >= RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
                end
            end
            S_STABLE: begin
                if (!w_good) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!w_good) begin
                    w_state_nxt = S_RESET_PLL;
                    w_loss      = 1'b1;
                end
            end
            S_FAULT: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_RESET_PLL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        stdy_rst = 1'b0;
        sys_rst  = 1'b1;
        ready    = 1'b0;
        fault    = 1'b0;
        case (r_state)
            S_RESET_PLL: stdy_rst = 1'b1;
            S_RUN: begin
                sys_rst = 1'b0;
                ready   = 1'b1;
            end
            S_FAULT:     fault = 1'b1;
            default: begin
                stdy_rst = 1'b0;
            end
        endcase
    end

    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry_count;
    assign loss_count  = r_loss_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: scenario tasks plus randomized lock chatter,
// checked against a countdown-style behavioural model of the sequencer.
module tb_pll_reset_sequencer;

    localparam int STDY   = 4;
    localparam int STABLE = 1024;
    localparam int TMO    = 100;
    localparam int MAXR   = 3;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       lk = 1'b0;
    logic       st = 1'b0;
    logic       stdy_rst, sys_rst, ready, lock_lost, fault;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .STDY_RST_CYCLES    (STDY),
        .LOCK_STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .clock_in       (clk),
        .rst_in         (rst_in),
        .pll_locked     (lk),
        .pll_locked_stdy(st),
        .stdy_rst       (stdy_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .lock_lost      (lock_lost),
        .fault          (fault),
        .retry_count    (retry_count),
        .loss_count     (loss_count)
    );

    // Behavioural model: phases with remaining-cycle countdowns
    localparam int PH_ARM = 0, PH_WAIT = 1, PH_QUAL = 2, PH_RUN = 3, PH_DEAD = 4;
    int       m_phase = PH_ARM;
    int       m_left = STDY;
    int       m_retries = 0;
    int       m_losses = 0;
    bit       m_lost = 1'b0;
    bit       m_good;
    bit [1:0] lk_h = 2'b00;
    bit [1:0] st_h = 2'b00;

    always @(posedge clk) begin
        if (rst_in) begin
            m_phase = PH_ARM; m_left = STDY; m_retries = 0; m_losses = 0;
            m_lost = 1'b0; lk_h = 2'b00; st_h = 2'b00;
        end else begin
            m_good = lk_h[1] & st_h[1];
            lk_h = {lk_h[0], lk};
            st_h = {st_h[0], st};
            m_lost = 1'b0;
            case (m_phase)
                PH_ARM: if (m_left == 1) begin m_phase = PH_WAIT; m_left = TMO; end
                        else m_left--;
                PH_WAIT: begin
                    if (m_good) begin m_phase = PH_QUAL; m_left = STABLE; end
                    else if (m_left == 1) begin
                        m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                        if (m_retries >= MAXR) m_phase = PH_DEAD;
                        else begin m_phase = PH_ARM; m_left = STDY; end
                    end else m_left--;
                end
                PH_QUAL: begin
                    if (!m_good) begin m_phase = PH_WAIT; m_left = TMO; end
                    else if (m_left == 1) m_phase = PH_RUN;
                    else m_left--;
                end
                PH_RUN: if (!m_good) begin
                    m_phase = PH_ARM; m_left = STDY; m_lost = 1'b1;
                    m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                end
                default: ;
            endcase
        end
    end

    logic [16:0] dut_vec, mdl_vec;
    assign dut_vec = {stdy_rst, sys_rst, ready, lock_lost, fault, retry_count, loss_count};
    assign mdl_vec = {m_phase == PH_ARM, m_phase != PH_RUN, m_phase == PH_RUN, m_lost,
                      m_phase == PH_DEAD, 4'(m_retries), 8'(m_losses)};

    task automatic test_reset();
        rst_in = 1'b1; lk = 1'b0; st = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (dut_vec !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            n_bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec, 17'h18000);
        end
        n_cmp++;
        if (dut_vec !== mdl_vec) begin
            n_bad++; $display("FAIL reset_model: got %h want %h", dut_vec, mdl_vec);
        end
    endtask

    task automatic test_clean_lock();
        int hi;
        int k;
        hi = int'(stdy_rst);
        rst_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hi += int'(stdy_rst);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL clean_arm cyc=%0d: got %h want %h", i, dut_vec, mdl_vec);
            end
        end
        n_cmp++;
        if (hi !== 4) begin n_bad++; $display("FAIL clean_stdy_width: got %0d want 4", hi); end
        lk = 1'b1; st = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL clean_qual cyc=%0d: got %h want %h", k, dut_vec, mdl_vec);
            end
        end while (sys_rst !== 1'b0 && k < 3000);
        n_cmp++;
        if (k !== STABLE + 3) begin
            n_bad++; $display("FAIL clean_release_latency: got %0d want %0d", k, STABLE + 3);
        end
        n_cmp++;
        if ({ready, lock_lost, fault, retry_count, loss_count} !== {1'b1, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            n_bad++; $display("FAIL clean_run_outputs: got r=%b f=%b rc=%0d lc=%0d want r=1 f=0 rc=0 lc=0",
                              ready, fault, retry_count, loss_count);
        end
    endtask

    task automatic test_loss_in_run();
        int hi;
        int pulses;
        repeat (5) @(negedge clk);
        st = 1'b0;
        hi = 0; pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            hi += int'(stdy_rst);
            pulses += int'(lock_lost);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL loss_model cyc=%0d: got %h want %h", i, dut_vec, mdl_vec);
            end
            if (i == 2) begin
                n_cmp++;
                if (ready !== 1'b1) begin n_bad++; $display("FAIL loss_still_ready: got %b want 1", ready); end
            end
            if (i == 3) begin
                n_cmp++;
                if ({sys_rst, ready, lock_lost, loss_count} !== {1'b1, 1'b0, 1'b1, 8'd1}) begin
                    n_bad++; $display("FAIL loss_exit: got sys=%b rdy=%b lost=%b lc=%0d want 1 0 1 1",
                                      sys_rst, ready, lock_lost, loss_count);
                end
            end
        end
        n_cmp++;
        if (hi !== 4 || pulses !== 1) begin
            n_bad++; $display("FAIL loss_pulses: got stdy=%0d lost=%0d want stdy=4 lost=1", hi, pulses);
        end
        st = 1'b1;
    endtask

    task automatic test_glitch_stable();
        int k;
        bit lost_seen;
        k = 0;
        while (!(m_phase == PH_QUAL && m_left == STABLE - 500) && k < 2000) begin
            @(negedge clk);
            k++;
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL glitch_approach cyc=%0d: got %h want %h", k, dut_vec, mdl_vec);
            end
        end
        n_cmp++;
        if (k >= 2000) begin n_bad++; $display("FAIL glitch_reach_stable: got timeout want cnt=500"); end
        lk = 1'b0;
        @(negedge clk);
        lk = 1'b1;
        k = 0; lost_seen = 1'b0;
        do begin
            @(negedge clk);
            k++;
            lost_seen |= lock_lost;
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL glitch_requal cyc=%0d: got %h want %h", k, dut_vec, mdl_vec);
            end
        end while (sys_rst !== 1'b0 && k < 3000);
        n_cmp++;
        if (k !== STABLE + 3) begin
            n_bad++; $display("FAIL glitch_requal_latency: got %0d want %0d", k, STABLE + 3);
        end
        n_cmp++;
        if ({lost_seen, retry_count, loss_count} !== {1'b0, 4'd0, 8'd1}) begin
            n_bad++; $display("FAIL glitch_counts: got lost=%b rc=%0d lc=%0d want 0 0 1",
                              lost_seen, retry_count, loss_count);
        end
    endtask

    task automatic test_reset_mid_stable();
        int k;
        lk = 1'b0;
        @(negedge clk);
        lk = 1'b1;
        k = 0;
        while (!(m_phase == PH_QUAL && m_left == 700) && k < 2000) begin
            @(negedge clk);
            k++;
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL midstable_approach cyc=%0d: got %h want %h", k, dut_vec, mdl_vec);
            end
        end
        n_cmp++;
        if (loss_count !== 8'd2) begin n_bad++; $display("FAIL midstable_pre_loss: got %0d want 2", loss_count); end
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0; lk = 1'b0; st = 1'b0;
        n_cmp++;
        if (dut_vec !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            n_bad++; $display("FAIL midstable_reset: got %h want %h", dut_vec, 17'h18000);
        end
    endtask

    task automatic test_timeout_fault();
        int pulses;
        bit prev;
        logic [3:0] seen[$];
        logic [3:0] last;
        prev = stdy_rst; pulses = int'(stdy_rst); last = retry_count;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (stdy_rst && !prev) pulses++;
            prev = stdy_rst;
            if (retry_count !== last) begin seen.push_back(retry_count); last = retry_count; end
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL timeout_model cyc=%0d: got %h want %h", i, dut_vec, mdl_vec);
            end
        end
        n_cmp++;
        if (pulses !== 3) begin n_bad++; $display("FAIL timeout_rearm_pulses: got %0d want 3", pulses); end
        n_cmp++;
        if (seen.size() !== 3 || seen[0] !== 4'd1 || seen[1] !== 4'd2 || seen[2] !== 4'd3) begin
            n_bad++; $display("FAIL timeout_retry_seq: got %0d steps last=%0d want 1,2,3", seen.size(), last);
        end
        n_cmp++;
        if ({fault, sys_rst, ready, stdy_rst} !== 4'b1100) begin
            n_bad++; $display("FAIL timeout_fault: got f/s/r/st=%b%b%b%b want 1100", fault, sys_rst, ready, stdy_rst);
        end
        lk = 1'b1; st = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL fault_hold cyc=%0d: got %h want %h", i, dut_vec, mdl_vec);
            end
        end
        n_cmp++;
        if ({fault, sys_rst, ready, retry_count} !== {1'b1, 1'b1, 1'b0, 4'd3}) begin
            n_bad++; $display("FAIL fault_sticky: got f=%b s=%b r=%b rc=%0d want 1 1 0 3",
                              fault, sys_rst, ready, retry_count);
        end
    endtask

    task automatic test_reset_mid_fault();
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        n_cmp++;
        if (dut_vec !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            n_bad++; $display("FAIL midfault_reset: got %h want %h", dut_vec, 17'h18000);
        end
    endtask

    task automatic test_random();
        int kind;
        int len;
        for (int seg = 0; seg < 14; seg++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                lk = 1'b1; st = 1'b1; len = $urandom_range(200, 1300);
            end else if (kind < 7) begin
                lk = $urandom_range(0, 1); st = ~lk | 1'($urandom_range(0, 1)) ? 1'b0 : 1'b1; len = 1;
            end else if (kind < 9) begin
                len = $urandom_range(1, 120);
            end else begin
                rst_in = 1'b1; len = $urandom_range(1, 3);
            end
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                n_cmp++;
                if (dut_vec !== mdl_vec) begin
                    n_bad++; $display("FAIL random seg=%0d cyc=%0d: got %h want %h", seg, i, dut_vec, mdl_vec);
                end
                if (kind == 7 || kind == 8) begin
                    lk = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1));
                end
            end
            rst_in = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_loss_in_run();
        test_glitch_stable();
        test_reset_mid_stable();
        test_timeout_fault();
        test_reset_mid_fault();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
